alu_share_ctrl: RTL
===================

Name: alu_share_ctrl

Overview:
- Controller that time-shares one combinational ALU (ADD on ALUctrl=000, EQ compare on ALUctrl=001) between two requesters, e.g. the address-generation path and the branch-compare path.
- Each requester uses valid/ready handshakes; arbitration is round-robin.
- The block drives the shared ALU, captures its result in a register and holds it until the requester accepts it.
- It also cleans up ALU outputs that are undefined for a given op.

Parameters:
DATA_WIDTH, 32, operand/result width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  2  bit i = requester i has an op
req_ready  out  2  bit i = op from requester i accepted this cycle
req_op1  in  2*DATA_WIDTH  requester i operand 1 in bits [i*DATA_WIDTH +: DATA_WIDTH]
req_op2  in  2*DATA_WIDTH  requester i operand 2, same packing
req_ctrl  in  6  requester i op code in bits [i*3 +: 3]
resp_valid  out  2  bit i = result for requester i is available
resp_ready  in  2  bit i = requester i takes the result
resp_result  out  DATA_WIDTH  result, qualified by resp_valid
resp_eq  out  1  compare flag, qualified by resp_valid
alu_op1  out  DATA_WIDTH  to shared ALU operand 1
alu_op2  out  DATA_WIDTH  to shared ALU operand 2
alu_ctrl  out  3  to shared ALU control
alu_out  in  DATA_WIDTH  from shared ALU sum
alu_eq  in  1  from shared ALU EQ
busy  out  1  state != IDLE
grant_id  out  1  index of the requester currently being served

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low. It is sampled only on the rising edge of clk.
- Reset values: state=IDLE, rr_ptr=0 (requester 0 preferred). Operand, ctrl and id registers, resp_result, resp_eq, resp_valid, busy and grant_id are all 0. alu_op1, alu_op2 and alu_ctrl are 0.
- Reset in any state, including mid-operation: the pending op is dropped and no response is produced. The next cycle is IDLE with all outputs at their reset values.
- States:
  - IDLE: waiting for a request.
  - EXEC: drives the ALU; exactly 1 cycle.
  - RESP: holds the response until accepted.
- Arbitration (combinational, IDLE only):
  - Only one req_valid bit set: that requester wins.
  - Both set: rr_ptr wins.
  - req_ready[i] = (state==IDLE) & win_i. At most one bit is set. req_ready is 00 in EXEC and RESP.
- Accept (IDLE, req_valid[i] & req_ready[i]):
  - Latch op1, op2, ctrl and id=i.
  - grant_id <= i.
  - Next state EXEC.
  - Payload is sampled only at the handshake. Dropping req_valid without a handshake is legal and has no effect.
- EXEC:
  - alu_op1, alu_op2 and alu_ctrl are driven directly from the latched registers. They hold their last values in other states and are valid only in EXEC.
  - At the end of EXEC, capture the result per this map:
    - ctrl=000: resp_result <= alu_out, resp_eq <= 0.
    - ctrl=001: resp_result <= 0, resp_eq <= alu_eq.
    - Any other ctrl: resp_result <= 0, resp_eq <= 0.
  - Then resp_valid[id] <= 1 and next state RESP.
- RESP:
  - resp_valid[id], resp_result and resp_eq stay stable until resp_ready[id]=1.
  - resp_ready on the other bit is ignored.
  - On handshake: resp_valid <= 00, rr_ptr <= ~id, next state IDLE.
- Timing:
  - Accept in cycle T: EXEC in T+1, resp_valid high from T+2.
  - With resp_ready tied high, the next accept is at T+3. Peak throughput is 1 op per 3 cycles.
- Arithmetic: the sum wraps modulo 2^DATA_WIDTH. No carry or overflow is reported.
- busy = (state != IDLE).

Test Plan:
- ADD: after reset, req0 op1=5, op2=7, ctrl=000, accepted at T. Required: busy=1 at T+1; resp_valid=01, resp_result=12, resp_eq=0 at T+2.
- EQ: req1 op1=op2=0xDEADBEEF, ctrl=001. Required: resp_valid=10, result=0, eq=1. Repeat with op2=0xDEADBEEE. Required: eq=0.
- Contention: both requesters hold valid continuously, resp_ready=11. Required: the grant order is 0,1,0,1. Accepts occur every 3 cycles, and req_ready is never 11.
- Backpressure: resp_ready=00 for 5 cycles in RESP while both req_valid are high. Required: resp_valid, result and eq stay stable; req_ready=00; no new accept. When resp_ready is raised, the release happens on the next edge.
- Wrap and undefined op: 0xFFFFFFFF + 1, ctrl=000. Required: result=0, eq=0. ctrl=111 with any operands. Required: result=0, eq=0, and the response is still delivered.
- Reset mid-op: assert rst_n=0 during EXEC, and separately during RESP. Required: the next cycle shows busy=0, resp_valid=00, all outputs 0, and requester 0 is preferred on the next contention.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin controller that time-shares one external ADD/EQ ALU between two
// requesters, registering each result until its requester takes it.
module alu_share_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_op1,
    input  logic [2*DATA_WIDTH-1:0] req_op2,
    input  logic [5:0]              req_ctrl,
    output logic [1:0]              resp_valid,
    input  logic [1:0]              resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_result,
    output logic                    resp_eq,
    output logic [DATA_WIDTH-1:0]   alu_op1,
    output logic [DATA_WIDTH-1:0]   alu_op2,
    output logic [2:0]              alu_ctrl,
    input  logic [DATA_WIDTH-1:0]   alu_out,
    input  logic                    alu_eq,
    output logic                    busy,
    output logic                    grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  rr_ptr;
    logic [DATA_WIDTH-1:0] op1_q, op2_q;
    logic [2:0]            ctrl_q;
    logic                  id_q;
    logic [1:0]            win;
    logic                  accept;
    logic                  accept_id;
    logic                  release_rsp;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; payload is sampled only then, and valid may drop without effect.
    always_comb begin
        win = req_valid;
        if (req_valid == 2'b11) begin
            win = rr_ptr ? 2'b10 : 2'b01;
        end
    end

    assign req_ready   = (state == IDLE) ? win : 2'b00;
    assign accept      = |(req_valid & req_ready);
    assign accept_id   = req_ready[1];
    assign release_rsp = (state == RESP) && resp_ready[id_q];

    assign alu_op1  = op1_q;
    assign alu_op2  = op2_q;
    assign alu_ctrl = ctrl_q;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (release_rsp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            ctrl_q      <= 3'b000;
            id_q        <= 1'b0;
            grant_id    <= 1'b0;
            resp_result <= '0;
            resp_eq     <= 1'b0;
            resp_valid  <= 2'b00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op1_q    <= accept_id ? req_op1[2*DATA_WIDTH-1:DATA_WIDTH] : req_op1[DATA_WIDTH-1:0];
                op2_q    <= accept_id ? req_op2[2*DATA_WIDTH-1:DATA_WIDTH] : req_op2[DATA_WIDTH-1:0];
                ctrl_q   <= accept_id ? req_ctrl[5:3] : req_ctrl[2:0];
                id_q     <= accept_id;
                grant_id <= accept_id;
            end
            // Only the output meaningful for the op is kept; the other is zeroed.
            if (state == EXEC) begin
                case (ctrl_q)
                    3'b000: begin
                        resp_result <= alu_out;
                        resp_eq     <= 1'b0;
                    end
                    3'b001: begin
                        resp_result <= '0;
                        resp_eq     <= alu_eq;
                    end
                    default: begin
                        resp_result <= '0;
                        resp_eq     <= 1'b0;
                    end
                endcase
                resp_valid <= id_q ? 2'b10 : 2'b01;
            end
            if (release_rsp) begin
                resp_valid <= 2'b00;
                rr_ptr     <= ~id_q;
            end
        end
    end

endmodule
